// File: rtl/ethernet_tx_buffer.sv
// Byte-addressed transmit buffer that streams a stored frame to a MAC one byte per handshake.
// Optional ETH_TX_PAD_EN: zero-pad frames shorter than 60 bytes up to 60 bytes.
module ethernet_tx_buffer #(
    parameter int eth_mtu_p    = 2048,
    parameter int data_width_p = 32
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                packet_wvalid_i,
    input  logic [$clog2(eth_mtu_p)-1:0]        packet_waddr_i,
    input  logic [data_width_p-1:0]             packet_wdata_i,
    input  logic [$clog2(data_width_p/8)-1:0]   packet_wdata_size_i,
    input  logic                                packet_wsize_valid_i,
    input  logic [$clog2(eth_mtu_p+1)-1:0]      packet_wsize_i,
    input  logic                                packet_send_i,
    output logic                                packet_req_o,
    output logic [7:0]                          tx_data_o,
    output logic                                tx_valid_o,
    output logic                                tx_last_o,
    input  logic                                tx_ready_i,
    input  logic                                tx_interrupt_clear_i,
    input  logic                                tx_interrupt_enable_i,
    input  logic                                tx_interrupt_enable_v_i,
    output logic                                tx_interrupt_pending_o,
    output logic                                tx_interrupt_o
);

    localparam int AW = $clog2(eth_mtu_p);
    localparam int LW = $clog2(eth_mtu_p + 1);
    localparam int NB = data_width_p / 8;

    typedef enum logic [1:0] {IDLE, PREFETCH, SEND} state_e;

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] data_len_q, data_len_d;
    logic [LW-1:0] total_q, total_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;
    logic          tx_last_q, tx_last_d;
    logic          pending_q, pending_d;
    logic          enable_q, enable_d;
    logic          pending_set;

    logic [7:0]    mem [eth_mtu_p];
    logic [NB-1:0] byte_we;
    logic [AW:0]   byte_addr [NB];

    // Addresses carry one extra bit so writes running past the end are dropped, not wrapped.
    always_comb begin
        for (int unsigned k = 0; k < NB; k++) begin
            byte_addr[k] = (AW+1)'(packet_waddr_i) + (AW+1)'(k);
            byte_we[k]   = (state_q == IDLE) && packet_wvalid_i
                           && (k < (32'd1 << packet_wdata_size_i))
                           && (byte_addr[k] < (AW+1)'(eth_mtu_p));
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < NB; k++) begin
            if (byte_we[k]) begin
                mem[byte_addr[k][AW-1:0]] <= packet_wdata_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            data_len_q <= '0;
            total_q    <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            pending_q  <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            data_len_q <= data_len_d;
            total_q    <= total_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (packet_send_i && (len_q != '0)) state_d = PREFETCH;
            PREFETCH: state_d = SEND;
            SEND:     if (tx_valid_q && tx_ready_i && tx_last_q) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        data_len_d  = data_len_q;
        total_d     = total_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        pending_set = 1'b0;

        len_d = len_q;
        if (packet_wsize_valid_i) begin
            len_d = (packet_wsize_i > LW'(eth_mtu_p)) ? LW'(eth_mtu_p) : packet_wsize_i;
        end

        case (state_q)
            IDLE: begin
                if (packet_send_i) begin
                    data_len_d = len_q;
`ifdef ETH_TX_PAD_EN
                    total_d    = (len_q < LW'(60)) ? LW'(60) : len_q;
`else
                    total_d    = len_q;
`endif
                    idx_d      = '0;
                    if (len_q == '0) pending_set = 1'b1;
                end
            end
            SEND: begin
                // Output register refills whenever it is empty or being drained.
                if (!tx_valid_q || tx_ready_i) begin
                    if (tx_valid_q && tx_last_q) begin
                        tx_valid_d  = 1'b0;
                        tx_last_d   = 1'b0;
                        pending_set = 1'b1;
                    end else begin
                        tx_valid_d = 1'b1;
                        tx_data_d  = (idx_q < data_len_q) ? mem[idx_q[AW-1:0]] : 8'h00;
                        tx_last_d  = (idx_q == total_q - LW'(1));
                        idx_d      = idx_q + LW'(1);
                    end
                end
            end
            default: ;
        endcase

        pending_d = (pending_q && !tx_interrupt_clear_i) || pending_set;
        enable_d  = tx_interrupt_enable_v_i ? tx_interrupt_enable_i : enable_q;
    end

    assign packet_req_o           = (state_q == IDLE);
    assign tx_data_o              = tx_data_q;
    assign tx_valid_o             = tx_valid_q;
    assign tx_last_o              = tx_last_q;
    assign tx_interrupt_pending_o = pending_q;
    assign tx_interrupt_o         = pending_q && enable_q;

endmodule

// File: doc/ethernet_tx_buffer.md
ETHERNET_TX_BUFFER -- requirements
Module: ethernet_tx_buffer

Interface
REQ-001 SHALL have parameter eth_mtu_p, default 2048, TX buffer size in bytes (<= 2048).
REQ-002 SHALL have parameter data_width_p, default 32, write data width in bits.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port packet_wvalid_i  input  1  buffer write strobe.
REQ-006 SHALL have port packet_waddr_i  input  clog2(eth_mtu_p)  write byte address.
REQ-007 SHALL have port packet_wdata_i  input  data_width_p  write data, byte k at packet_waddr_i+k.
REQ-008 SHALL have port packet_wdata_size_i  input  clog2(data_width_p/8)  log2 of write byte count.
REQ-009 SHALL have port packet_wsize_valid_i  input  1  frame length write strobe.
REQ-010 SHALL have port packet_wsize_i  input  clog2(eth_mtu_p+1)  frame length in bytes.
REQ-011 SHALL have port packet_send_i  input  1  start-transmit pulse.
REQ-012 SHALL have port packet_req_o  output  1  idle, ready for writes and send.
REQ-013 SHALL have ports tx_data_o/tx_valid_o/tx_last_o  output  8/1/1  byte stream to MAC.
REQ-014 SHALL have port tx_ready_i  input  1  MAC accepts byte.
REQ-015 SHALL have port tx_interrupt_clear_i  input  1  pending clear pulse.
REQ-016 SHALL have ports tx_interrupt_enable_i/tx_interrupt_enable_v_i  input  1/1  enable value and its write strobe.
REQ-017 SHALL have ports tx_interrupt_pending_o/tx_interrupt_o  output  1/1  pending flag; pending AND enable.

Function
REQ-018 SHALL implement states IDLE, PREFETCH, SEND; packet_req_o = (state == IDLE).
REQ-019 SHALL in IDLE on packet_wvalid_i write 2^packet_wdata_size_i bytes little-endian; bytes at address >= eth_mtu_p dropped.
REQ-020 SHALL ignore packet_wvalid_i in PREFETCH/SEND (buffer unchanged).
REQ-021 SHALL latch packet_wsize_i into the length register on packet_wsize_valid_i in any state, clamped to eth_mtu_p.
REQ-022 SHALL on packet_send_i in IDLE latch the length register into the frame count and go to PREFETCH; length 0 instead sets pending next cycle and stays IDLE.
REQ-023 SHALL ignore packet_send_i outside IDLE.
REQ-024 SHALL first assert tx_valid_o exactly 2 cycles after packet_send_i is sampled, carrying buffer byte 0.
REQ-025 SHALL emit bytes 0..N-1 in order, advancing one byte per cycle with tx_valid_o & tx_ready_i (full throughput, no bubbles).
REQ-026 SHALL hold tx_data_o/tx_last_o stable while tx_valid_o & ~tx_ready_i.
REQ-027 SHALL assert tx_last_o only with the final byte; on its handshake go IDLE and set pending next cycle.
REQ-028 SHALL clear pending on tx_interrupt_clear_i; simultaneous set and clear leaves pending set.
REQ-029 SHALL update the enable register on tx_interrupt_enable_v_i.

Reset
REQ-030 SHALL in reset force state IDLE, packet_req_o=1, tx_valid_o=0, tx_last_o=0, tx_data_o=0, pending=0, enable=0, length=0; buffer contents not reset.
REQ-031 SHALL on reset mid-frame abort: tx_valid_o low the cycle after reset sampled, pending not set.

Configuration
REQ-032 SHALL, with ETH_TX_PAD_EN defined, pad frames with N<60 with zero bytes to 60 total, tx_last_o on byte 59.
REQ-033 SHALL, without ETH_TX_PAD_EN, emit exactly N bytes.

Verification
REQ-034 SHALL cover: write 0x44332211 size 2 at addr 0, 0x55 size 0 at addr 4, length 5, send, tx_ready_i=1 -> bytes 11,22,33,44,55 on consecutive cycles, last on 55, pending set next cycle.
REQ-035 SHALL cover: tx_ready_i toggled every cycle during 5-byte send -> each byte held stable until accepted, no loss or duplication.
REQ-036 SHALL cover: length 0 send -> no tx_valid_o, pending=1 next cycle, packet_req_o stays 1.
REQ-037 SHALL cover: length 3000 -> 2048 bytes emitted; size-2 write at addr 2046 -> only 2 bytes stored; write during SEND -> buffer unchanged.
REQ-038 SHALL cover: clear coincident with pending set -> pending stays 1; enable=1 -> tx_interrupt_o=1; reset at byte 2 -> tx_valid_o=0 next cycle, pending=0.
REQ-039 SHALL cover: ETH_TX_PAD_EN, length 10 -> 60 bytes, bytes 10..59 zero, last on byte 59.
